// File: rtl/y86_pkg.sv
// Shared Y86 fetch definitions: instruction window size, default
// instruction-memory depth and the fetch FSM state encoding.
package y86_pkg;

  localparam int IMEM_DEPTH  = 1024;
  localparam int INSTR_BYTES = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_ram.sv
// Byte-wide instruction storage: one synchronous write port and one
// asynchronous read port. Contents are never reset.
module imem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Write port: a read of the same address this cycle still sees the old byte
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Asynchronous read port
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/instr_mem.sv
// Y86 instruction memory with a byte-serial fetch of an INSTR_BYTES window.
// A request accepted in IDLE reads PC, PC+1, ... one byte per cycle into
// instruct (first byte ends up in the MSB), then pulses valid in DONE.
// Optional macro IMEM_RANGE_CHECK_EN: windows running past DEPTH-1 are
// rejected with mem_err instead of wrapping around modulo DEPTH.
module instr_mem #(
  parameter int DEPTH       = y86_pkg::IMEM_DEPTH,
  parameter int INSTR_BYTES = y86_pkg::INSTR_BYTES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  input  logic [63:0]              PC,
  input  logic                     wr_en,
  input  logic [63:0]              wr_addr,
  input  logic [7:0]               wr_data,
  output logic                     busy,
  output logic                     valid,
  output logic [8*INSTR_BYTES-1:0] instruct,
  output logic                     mem_err
);

  import y86_pkg::*;

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         IW       = 8 * INSTR_BYTES;
  localparam logic [3:0] LAST_CNT = 4'(INSTR_BYTES - 1);

  imem_state_e   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [63:0]   pc_q, pc_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [63:0]   addr_full;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_idx;
  logic          ram_we;
  logic [7:0]    rd_data;

`ifdef IMEM_RANGE_CHECK_EN
  logic mem_err_q, mem_err_d;
  logic oor;

  // Window end compared in 65 bits so PC near 2^64 cannot wrap into range
  assign oor = ({1'b0, PC} + 65'(INSTR_BYTES - 1)) > 65'(DEPTH - 1);
`endif

  // Writes beyond the array are dropped; writes are accepted in any state
  assign ram_we = wr_en && (wr_addr < 64'(DEPTH));
  assign wr_idx = AW'(wr_addr);

  // Fetch address; the modulo gives wrap-around and is a no-op for
  // range-checked windows, which never reach DEPTH
  assign addr_full = pc_q + 64'(cnt_q);
  assign rd_addr   = AW'(addr_full % 64'(DEPTH));

  imem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_idx),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Control and output state, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      instr_q   <= '0;
`ifdef IMEM_RANGE_CHECK_EN
      mem_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      instr_q   <= instr_d;
`ifdef IMEM_RANGE_CHECK_EN
      mem_err_q <= mem_err_d;
`endif
    end
  end

  // Latched start address; only meaningful after an accepted request
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

  // Next-state logic: req is only looked at in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
`ifdef IMEM_RANGE_CHECK_EN
          state_d = oor ? DONE : READ;
`else
          state_d = READ;
`endif
        end
      end
      READ:    if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch on acceptance, shift one byte in per READ cycle
  always_comb begin
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    instr_d   = instr_q;
`ifdef IMEM_RANGE_CHECK_EN
    mem_err_d = mem_err_q;
`endif
    if (state_q == IDLE && req) begin
      pc_d      = PC;
      cnt_d     = 4'd0;
      instr_d   = '0;
`ifdef IMEM_RANGE_CHECK_EN
      mem_err_d = oor;
`endif
    end else if (state_q == READ) begin
      instr_d = {instr_q[IW-9:0], rd_data};
      cnt_d   = (cnt_q == LAST_CNT) ? 4'd0 : cnt_q + 4'd1;
    end
  end

  // Outputs decoded from state; instruct/mem_err hold until next acceptance
  always_comb begin
    busy     = (state_q != IDLE);
    valid    = (state_q == DONE);
    instruct = instr_q;
`ifdef IMEM_RANGE_CHECK_EN
    mem_err  = mem_err_q;
`else
    mem_err  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_instr_mem.sv
// Directed bench for instr_mem (default parameters, DEPTH=1024).
module tb_instr_mem;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [63:0] PC;
  logic        wr_en;
  logic [63:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        valid;
  logic [79:0] instruct;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  localparam logic [79:0] EXP66 = 80'h35530000000000000006;

  instr_mem dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .PC       (PC),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .valid    (valid),
    .instruct (instruct),
    .mem_err  (mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  // Called and returns right after a negedge
  task automatic write_byte(input logic [63:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Issue a request at the current negedge and follow it cycle by cycle.
  // lat = cycle (after acceptance) in which valid is expected.
  task automatic run_fetch(input string name, input logic [63:0] pc,
                           input logic [79:0] exp_i, input logic exp_e,
                           input int lat, input logic hold,
                           input logic [63:0] pc_mid, input int wk,
                           input logic [63:0] wa0, input logic [63:0] wa1,
                           input logic [7:0] wd);
    req = 1'b1; PC = pc;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (!hold) req = 1'b0;
      if (k == 3) PC = pc_mid;
      if (wk != 0 && k == wk) begin
        wr_en = 1'b1; wr_addr = wa0; wr_data = wd;
      end else if (wk != 0 && k == wk + 1) begin
        wr_en = 1'b1; wr_addr = wa1; wr_data = wd;
      end else begin
        wr_en = 1'b0;
      end
      checks++;
      if (busy !== 1'b1 || valid !== 1'(k == lat)) begin
        errors++;
        $display("FAIL %s cycle %0d: busy=%b valid=%b, required busy=1 valid=%b",
                 name, k, busy, valid, (k == lat));
      end
      if (k == lat) begin
        checks++;
        if (instruct !== exp_i) begin
          errors++;
          $display("FAIL %s instruct: got %h, required %h", name, instruct, exp_i);
        end
        checks++;
        if (mem_err !== exp_e) begin
          errors++;
          $display("FAIL %s mem_err: got %b, required %b", name, mem_err, exp_e);
        end
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || instruct !== exp_i || mem_err !== exp_e) begin
      errors++;
      $display("FAIL %s after: busy=%b valid=%b instruct=%h mem_err=%b, required 0 0 %h %b",
               name, busy, valid, instruct, mem_err, exp_i, exp_e);
    end
  endtask

  task automatic test_reset();
    req = 1'b0; PC = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b, required 0", busy); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b, required 0", valid); end
    checks++;
    if (instruct !== 80'h0) begin errors++; $display("FAIL reset instruct: got %h, required 0", instruct); end
    checks++;
    if (mem_err !== 1'b0) begin errors++; $display("FAIL reset mem_err: got %b, required 0", mem_err); end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) write_byte(64'(i), 8'h00);
  endtask

  task automatic test_basic();
    logic [7:0] prog [10] = '{8'h35, 8'h53, 8'h00, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h06};
    for (int i = 0; i < 10; i++) write_byte(64'(66 + i), prog[i]);
    // Out-of-range write that would alias onto address 66 if not dropped
    write_byte(64'(DEPTH + 66), 8'hEE);
    run_fetch("basic_pc66", 64'd66, EXP66, 1'b0, 11, 1'b0, 64'd66, 0, '0, '0, 8'h00);
  endtask

  task automatic test_partial();
    write_byte(64'd2, 8'h20);
    write_byte(64'd3, 8'h03);
    run_fetch("partial_pc2", 64'd2, 80'h20030000000000000000, 1'b0, 11, 1'b0,
              64'd2, 0, '0, '0, 8'h00);
    write_byte(64'd4, 8'h40);
    run_fetch("partial_pc2_b4", 64'd2, 80'h20034000000000000000, 1'b0, 11, 1'b0,
              64'd2, 0, '0, '0, 8'h00);
  endtask

  task automatic test_back_to_back();
    // req held high, PC switched to 2 mid-fetch: first result is PC=66 only,
    // then one IDLE cycle and a fresh acceptance picks up PC=2
    run_fetch("hold_pc66", 64'd66, EXP66, 1'b0, 11, 1'b1, 64'd2, 0, '0, '0, 8'h00);
    run_fetch("hold_next_pc2", 64'd2, 80'h20034000000000000000, 1'b0, 11, 1'b0,
              64'd2, 0, '0, '0, 8'h00);
  endtask

  task automatic test_reset_mid();
    req = 1'b1; PC = 64'd66;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      req = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || instruct !== 80'h0 || mem_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset outputs: busy=%b valid=%b instruct=%h mem_err=%b, required all 0",
               busy, valid, instruct, mem_err);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset hold %0d: busy=%b valid=%b, required 0 0", k, busy, valid);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset release: busy=%b valid=%b, required 0 0", busy, valid);
    end
    run_fetch("after_reset_pc66", 64'd66, EXP66, 1'b0, 11, 1'b0, 64'd66, 0, '0, '0, 8'h00);
  endtask

  task automatic test_rdwr();
    // Address 40 is read in cycle 7 after acceptance: same-cycle write gives old byte.
    // Address 43 written in cycle 8, read in cycle 10: new byte.
    run_fetch("rdwr_pc34", 64'd34, 80'h000000000000000000AA, 1'b0, 11, 1'b0,
              64'd34, 7, 64'd40, 64'd43, 8'hAA);
    run_fetch("rdwr_refetch", 64'd34, 80'h000000000000AA0000AA, 1'b0, 11, 1'b0,
              64'd34, 0, '0, '0, 8'h00);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) begin
      write_byte(64'(DEPTH - 5 + i), 8'(8'h11 + i));
      write_byte(64'(i), 8'(8'h01 + i));
    end
    run_fetch("edge_pc_depth_m10", 64'(DEPTH - 10), 80'h00000000001112131415, 1'b0, 11,
              1'b0, 64'(DEPTH - 10), 0, '0, '0, 8'h00);
`ifdef IMEM_RANGE_CHECK_EN
    run_fetch("oor_pc_depth_m5", 64'(DEPTH - 5), 80'h0, 1'b1, 1, 1'b0,
              64'(DEPTH - 5), 0, '0, '0, 8'h00);
    run_fetch("oor_pc_huge", 64'hFFFF_FFFF_FFFF_FFFA, 80'h0, 1'b1, 1, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFA, 0, '0, '0, 8'h00);
`else
    run_fetch("wrap_pc_depth_m5", 64'(DEPTH - 5), 80'h11121314150102030405, 1'b0, 11,
              1'b0, 64'(DEPTH - 5), 0, '0, '0, 8'h00);
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_back_to_back();
    test_reset_mid();
    test_rdwr();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
